// File: rtl/ddr_arb_pkg.sv
// Shared state encoding, command constants and timeout defaults for the
// two-port DDR controller arbiter.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        ARB        = 3'd0,
        ISSUE      = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        RELEASE    = 3'd4
    } arb_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int DEF_START_TO = 16;
    localparam int DEF_DONE_TO  = 1000000;
    localparam int WD_W         = 24;

    // Holds at all-ones so a stalled controller can never wrap the count
    // back under a timeout limit.
    function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin picker: combinational pick, registered pointer
// holding the index of the last port that completed a transaction.
module rr_arbiter2 (
    input  logic       AXI_CLK,
    input  logic       usr_rstn,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       update_idx,
    output logic       pick_valid,
    output logic       pick_idx
);

    logic last;

    // Reset to "port 1 went last" so port 0 wins the first tie.
    always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
        if (!usr_rstn) begin
            last <= 1'b1;
        end else if (update) begin
            last <= update_idx;
        end
    end

    always_comb begin
        pick_valid = |req;
        pick_idx   = req[1];
        if (&req) begin
            pick_idx = ~last;
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one ddr_dram_controller user command port between the camera write
// path (port 0) and the display read path (port 1), with a stall watchdog.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int START_TO = DEF_START_TO,
    parameter int DONE_TO  = DEF_DONE_TO
) (
    input  logic              AXI_CLK,
    input  logic              usr_rstn,
    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [LEN_W-1:0]  p0_alen,
    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LEN_W-1:0]  p1_alen,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_done,
    output logic              p1_done,
    output logic              p0_err,
    output logic              p1_err,
    output logic              ctrl_write,
    output logic              ctrl_read,
    output logic [ADDR_W-1:0] ctrl_waddr,
    output logic [ADDR_W-1:0] ctrl_raddr,
    output logic [LEN_W-1:0]  ctrl_wd_alen,
    output logic [LEN_W-1:0]  ctrl_rd_alen,
    input  logic              ctrl_idle,
    input  logic              ctrl_done,
    output logic              owner,
    output logic              busy
);

    localparam logic [WD_W-1:0] START_LIM = WD_W'(START_TO - 1);
    localparam logic [WD_W-1:0] DONE_LIM  = WD_W'(DONE_TO - 1);

    arb_state_e        state, state_next;
    logic [WD_W-1:0]   wd;
    logic              rw_q;

    logic              pick_valid;
    logic              pick_idx;
    logic              grant_en;
    logic              issue_en;
    logic              wd_clr;
    logic              wd_run;
    logic              finish_done;
    logic              finish_err;

    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_alen;

    rr_arbiter2 u_rr (
        .AXI_CLK    (AXI_CLK),
        .usr_rstn   (usr_rstn),
        .req        ({p1_req, p0_req}),
        .update     (finish_done),
        .update_idx (owner),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    assign sel_rw   = pick_idx ? p1_rw   : p0_rw;
    assign sel_addr = pick_idx ? p1_addr : p0_addr;
    assign sel_alen = pick_idx ? p1_alen : p0_alen;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
        if (!usr_rstn) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        grant_en    = 1'b0;
        issue_en    = 1'b0;
        wd_clr      = 1'b0;
        wd_run      = 1'b0;
        finish_done = 1'b0;
        finish_err  = 1'b0;
        case (state)
            ARB: begin
                if (ctrl_idle && pick_valid) begin
                    grant_en   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                issue_en   = 1'b1;
                wd_clr     = 1'b1;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                wd_run = 1'b1;
                // A done pulse before the controller is seen busy is a
                // legitimate very short transaction.
                if (ctrl_done) begin
                    finish_done = 1'b1;
                    state_next  = RELEASE;
                end else if (!ctrl_idle) begin
                    wd_clr     = 1'b1;
                    state_next = WAIT_DONE;
                end else if (wd >= START_LIM) begin
                    finish_err = 1'b1;
                    state_next = RELEASE;
                end
            end
            WAIT_DONE: begin
                wd_run = 1'b1;
                if (ctrl_done) begin
                    finish_done = 1'b1;
                    state_next  = RELEASE;
                end else if (wd >= DONE_LIM) begin
                    finish_err = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (ctrl_idle) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    always_ff @(posedge AXI_CLK or negedge usr_rstn) begin
        if (!usr_rstn) begin
            wd           <= '0;
            rw_q         <= RW_READ;
            owner        <= 1'b0;
            busy         <= 1'b0;
            p0_gnt       <= 1'b0;
            p1_gnt       <= 1'b0;
            p0_done      <= 1'b0;
            p1_done      <= 1'b0;
            p0_err       <= 1'b0;
            p1_err       <= 1'b0;
            ctrl_write   <= 1'b0;
            ctrl_read    <= 1'b0;
            ctrl_waddr   <= '0;
            ctrl_raddr   <= '0;
            ctrl_wd_alen <= '0;
            ctrl_rd_alen <= '0;
        end else begin
            busy       <= (state_next != ARB);
            ctrl_write <= issue_en && (rw_q == RW_WRITE);
            ctrl_read  <= issue_en && (rw_q == RW_READ);
            p0_done    <= finish_done && !owner;
            p1_done    <= finish_done &&  owner;
            p0_err     <= finish_err  && !owner;
            p1_err     <= finish_err  &&  owner;

            if (wd_clr) begin
                wd <= '0;
            end else if (wd_run) begin
                wd <= wd_sat_inc(wd);
            end

            // Both bus pairs carry the winner's request; the controller
            // only looks at the pair matching the strobe.
            if (grant_en) begin
                owner        <= pick_idx;
                rw_q         <= sel_rw;
                ctrl_waddr   <= sel_addr;
                ctrl_raddr   <= sel_addr;
                ctrl_wd_alen <= sel_alen;
                ctrl_rd_alen <= sel_alen;
                p0_gnt       <= !pick_idx;
                p1_gnt       <=  pick_idx;
            end else if (finish_done || finish_err) begin
                p0_gnt <= 1'b0;
                p1_gnt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Scoreboard bench for ddr_port_arbiter: a behavioural controller model,
// a round-robin reference model and a decoupled output monitor.
module tb_ddr_port_arbiter;

    localparam int ADDR_W   = 32;
    localparam int LEN_W    = 8;
    localparam int START_TO = 16;
    localparam int DONE_TO  = 100;
    localparam int HANG     = 150;

    typedef enum int {OUT_DONE, OUT_ERR_START, OUT_ERR_DONE} oc_e;
    typedef enum int {M_RAND, M_FIXED, M_NOSTART, M_NODONE} mode_e;

    typedef struct {
        bit          port;
        bit          rw;
        logic [31:0] addr;
        logic [7:0]  alen;
        oc_e         oc;
    } txn_t;

    logic              AXI_CLK;
    logic              usr_rstn;
    logic              p0_req, p1_req, p0_rw, p1_rw;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [LEN_W-1:0]  p0_alen, p1_alen;
    logic              p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err;
    logic              ctrl_write, ctrl_read;
    logic [ADDR_W-1:0] ctrl_waddr, ctrl_raddr;
    logic [LEN_W-1:0]  ctrl_wd_alen, ctrl_rd_alen;
    logic              ctrl_idle, ctrl_done;
    logic              owner, busy;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    mode_e ctl_mode = M_RAND;
    bit    rr_last = 1'b1;
    txn_t  exp_q[$];

    ddr_port_arbiter #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .START_TO(START_TO), .DONE_TO(DONE_TO)
    ) dut (
        .AXI_CLK(AXI_CLK), .usr_rstn(usr_rstn),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_alen(p0_alen),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_alen(p1_alen),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_done(p0_done), .p1_done(p1_done),
        .p0_err(p0_err), .p1_err(p1_err),
        .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
        .ctrl_waddr(ctrl_waddr), .ctrl_raddr(ctrl_raddr),
        .ctrl_wd_alen(ctrl_wd_alen), .ctrl_rd_alen(ctrl_rd_alen),
        .ctrl_idle(ctrl_idle), .ctrl_done(ctrl_done),
        .owner(owner), .busy(busy)
    );

    initial begin
        AXI_CLK = 1'b0;
        forever #5 AXI_CLK = ~AXI_CLK;
    end

    always @(posedge AXI_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input bit port, input bit rw, input logic [31:0] addr,
                                input logic [7:0] alen, input oc_e oc);
        txn_t t;
        t.port = port; t.rw = rw; t.addr = addr; t.alen = alen; t.oc = oc;
        return t;
    endfunction

    // Controller model -----------------------------------------------------
    task automatic wait_cyc(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge AXI_CLK);
            if (!usr_rstn) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    task automatic serve();
        int    sd, dd;
        bit    ab;
        mode_e m;
        m = ctl_mode;
        case (m)
            M_NOSTART: return;
            M_FIXED:   begin sd = 2; dd = 20; end
            M_NODONE:  begin sd = 2; dd = 0;  end
            default: begin
                sd = $urandom_range(0, 4);
                dd = (sd == 0) ? $urandom_range(1, 10) : $urandom_range(1, 30);
            end
        endcase
        if (sd != 0) begin
            wait_cyc(sd, ab);
            if (ab) begin ctrl_idle = 1'b1; ctrl_done = 1'b0; return; end
            ctrl_idle = 1'b0;
            if (m == M_NODONE) begin
                wait_cyc(HANG, ab);
                ctrl_idle = 1'b1;
                return;
            end
        end
        wait_cyc(dd, ab);
        if (ab) begin ctrl_idle = 1'b1; ctrl_done = 1'b0; return; end
        ctrl_done = 1'b1;
        wait_cyc(1, ab);
        ctrl_done = 1'b0;
        if (!ab) wait_cyc(1, ab);
        ctrl_idle = 1'b1;
    endtask

    initial begin
        ctrl_idle = 1'b1;
        ctrl_done = 1'b0;
        forever begin
            @(negedge AXI_CLK);
            if (usr_rstn && (ctrl_write || ctrl_read)) serve();
        end
    end

    // Monitor --------------------------------------------------------------
    txn_t cur;
    bit   cur_valid = 1'b0;
    int   issue_cyc = 0, last_cmp_cyc = -100, idle_fall_cyc = 0, last_cdone_cyc = -100;
    bit   idle_prev = 1'b1;

    initial begin
        logic [3:0] exp_vec;
        forever begin
            @(negedge AXI_CLK);
            #1;
            if (!usr_rstn) begin
                cur_valid    = 1'b0;
                last_cmp_cyc = -100;
                idle_prev    = 1'b1;
                continue;
            end
            if (idle_prev && !ctrl_idle) idle_fall_cyc = cyc;
            if (ctrl_done) last_cdone_cyc = cyc;
            if (ctrl_write || ctrl_read) begin
                check("one_strobe", ctrl_write && ctrl_read, 0);
                check("strobe_while_idle", ctrl_idle, 1);
                check("strobe_expected", exp_q.size() > 0, 1);
                check("gap_after_prev", (cyc - last_cmp_cyc) >= 3, 1);
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    issue_cyc = cyc;
                    check("strobe_rw", ctrl_write, cur.rw);
                    check("gnt", {p1_gnt, p0_gnt}, cur.port ? 2'b10 : 2'b01);
                    check("owner", owner, cur.port);
                    check("busy", busy, 1);
                    check("waddr", ctrl_waddr, cur.addr);
                    check("raddr", ctrl_raddr, cur.addr);
                    check("wd_alen", ctrl_wd_alen, cur.alen);
                    check("rd_alen", ctrl_rd_alen, cur.alen);
                end
            end
            if (p0_done || p1_done || p0_err || p1_err) begin
                check("completion_expected", cur_valid, 1);
                if (cur_valid) begin
                    if (cur.oc == OUT_DONE) exp_vec = cur.port ? 4'b0010 : 4'b0001;
                    else                    exp_vec = cur.port ? 4'b1000 : 4'b0100;
                    check("completion_kind", {p1_err, p0_err, p1_done, p0_done}, exp_vec);
                    check("gnt_dropped", {p1_gnt, p0_gnt}, 0);
                    case (cur.oc)
                        OUT_DONE:      check("done_latency", cyc - last_cdone_cyc, 1);
                        OUT_ERR_START: check("start_timeout_window",
                                             (cyc - issue_cyc) >= START_TO &&
                                             (cyc - issue_cyc) <= START_TO + 1, 1);
                        default:       check("done_timeout_window",
                                             (cyc - idle_fall_cyc) >= DONE_TO &&
                                             (cyc - idle_fall_cyc) <= DONE_TO + 2, 1);
                    endcase
                    cur_valid    = 1'b0;
                    last_cmp_cyc = cyc;
                end
            end
            idle_prev = ctrl_idle;
        end
    end

    // Stimulus -------------------------------------------------------------
    task automatic push_exp(input txn_t t);
        exp_q.push_back(t);
        if (t.oc == OUT_DONE) rr_last = t.port;
    endtask

    task automatic run_round(input bit r0, input bit r1, input txn_t t0, input txn_t t1,
                             input int reps1, input int budget);
        int left, got1;
        bit first;
        @(negedge AXI_CLK);
        p0_rw = t0.rw; p0_addr = t0.addr; p0_alen = t0.alen;
        p1_rw = t1.rw; p1_addr = t1.addr; p1_alen = t1.alen;
        p0_req = r0;
        p1_req = r1;
        if (r0 && r1) begin
            first = !rr_last;
            push_exp(first ? t1 : t0);
            push_exp(first ? t0 : t1);
        end else if (r0) begin
            push_exp(t0);
        end else begin
            for (int i = 0; i < reps1; i++) push_exp(t1);
        end
        left = int'(r0) + (r1 ? reps1 : 0);
        got1 = 0;
        for (int i = 0; i < budget && left > 0; i++) begin
            @(negedge AXI_CLK);
            if (p0_done || p0_err) begin p0_req = 1'b0; left--; end
            if (p1_done || p1_err) begin
                got1++;
                if (got1 >= reps1) p1_req = 1'b0;
                left--;
            end
        end
        check("round_complete", left, 0);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {p0_gnt, p1_gnt, p0_done, p1_done, p0_err, p1_err,
                             ctrl_write, ctrl_read, owner, busy}, 0);
        check({tag, "_addr"}, {ctrl_waddr, ctrl_raddr}, 0);
        check({tag, "_alen"}, {ctrl_wd_alen, ctrl_rd_alen}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        txn_t a, b;
        int   pat;
        usr_rstn = 1'b0;
        p0_req = 0; p1_req = 0; p0_rw = 0; p1_rw = 0;
        p0_addr = '0; p1_addr = '0; p0_alen = '0; p1_alen = '0;
        repeat (3) @(negedge AXI_CLK);
        check_all_zero("reset");
        usr_rstn = 1'b1;
        repeat (2) @(negedge AXI_CLK);

        // Simultaneous requests after reset alternate p0, p1, p0, p1.
        ctl_mode = M_FIXED;
        a = mk(0, 1'b1, 32'h0000_0000, 8'd3, OUT_DONE);
        b = mk(1, 1'b0, 32'h0000_8000, 8'd15, OUT_DONE);
        run_round(1, 1, a, b, 1, 200);
        run_round(1, 1, a, b, 1, 200);

        // Single p0 write with fixed controller timing.
        run_round(1, 0, mk(0, 1'b1, 32'h0000_1000, 8'd7, OUT_DONE), b, 1, 200);

        // p1 holds request: back-to-back reads.
        ctl_mode = M_RAND;
        run_round(0, 1, a, mk(1, 1'b0, 32'h0004_0000, 8'd31, OUT_DONE), 3, 400);

        // Controller never leaves idle: start timeout.
        ctl_mode = M_NOSTART;
        run_round(1, 0, mk(0, 1'b0, 32'h0000_2200, 8'd1, OUT_ERR_START), b, 1, 100);
        repeat (3) @(negedge AXI_CLK);
        check("busy_after_start_err", busy, 0);

        // Controller stalls busy: done timeout, next grant waits for idle.
        ctl_mode = M_NODONE;
        run_round(0, 1, a, mk(1, 1'b1, 32'h0010_0000, 8'd63, OUT_ERR_DONE), 1, 400);
        ctl_mode = M_RAND;
        run_round(1, 0, mk(0, 1'b1, 32'h0000_3000, 8'd2, OUT_DONE), b, 1, 400);

        // Randomised mixed traffic.
        for (int r = 0; r < 25; r++) begin
            pat = $urandom_range(1, 3);
            a = mk(0, 1'($urandom_range(0, 1)), $urandom(), 8'($urandom_range(0, 255)), OUT_DONE);
            b = mk(1, 1'($urandom_range(0, 1)), $urandom(), 8'($urandom_range(0, 255)), OUT_DONE);
            run_round(pat[0], pat[1], a, b, 1, 300);
        end

        // Reset in WAIT_DONE after a completed p0 transaction.
        ctl_mode = M_FIXED;
        run_round(1, 0, mk(0, 1'b1, 32'h0000_5000, 8'd4, OUT_DONE), b, 1, 200);
        @(negedge AXI_CLK);
        p0_rw = 1'b1; p0_addr = 32'h0000_6000; p0_alen = 8'd9; p0_req = 1'b1;
        exp_q.push_back(mk(0, 1'b1, 32'h0000_6000, 8'd9, OUT_DONE));
        for (int i = 0; i < 40; i++) begin
            if (!ctrl_idle) break;
            @(negedge AXI_CLK);
        end
        repeat (3) @(negedge AXI_CLK);
        check("busy_before_abort", busy, 1);
        #2 usr_rstn = 1'b0;
        #1 check_all_zero("async_reset");
        p0_req = 1'b0;
        rr_last = 1'b1;
        repeat (3) @(negedge AXI_CLK);
        usr_rstn = 1'b1;
        repeat (2) @(negedge AXI_CLK);
        ctl_mode = M_RAND;
        run_round(1, 1, mk(0, 1'b0, 32'h0000_7000, 8'd0, OUT_DONE),
                        mk(1, 1'b1, 32'h0000_9000, 8'd255, OUT_DONE), 1, 300);

        repeat (5) @(negedge AXI_CLK);
        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
